// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } dmem_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational alignment check: flags misaligned half/word accesses and the illegal size code.
module dmem_align_chk
    import dmem_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b1;
        unique case (size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = addr_lo[0];
            SIZE_W:  misaligned = |addr_lo;
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Single-outstanding load/store bridge from the MEM stage to a two-phase (address, data) bus,
// returning raw read data or an alignment error over a valid/ready response port.
module dmem_bus_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [1:0]          req_size,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic                cancel,

    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,

    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W/8-1:0] data_wstrb,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
);

    dmem_state_e         state_q, state_d;
    logic                drop_q, drop_d;
    logic                data_wr_q, data_wr_d;
    logic [1:0]          data_size_q, data_size_d;
    logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
    logic [DATA_W-1:0]   data_wdata_q, data_wdata_d;
    logic [DATA_W/8-1:0] data_wstrb_q, data_wstrb_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic                misaligned;

    dmem_align_chk u_align_chk (
        .size       (req_size),
        .addr_lo    (req_addr[1:0]),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        data_wr_d    = data_wr_q;
        data_size_d  = data_size_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        data_wstrb_d = data_wstrb_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && !cancel) begin
                    data_wr_d    = req_wr;
                    data_size_d  = req_size;
                    data_addr_d  = req_addr;
                    data_wdata_d = req_wdata;
                    data_wstrb_d = req_wr ? req_wstrb : '0;
                    resp_rdata_d = '0;
                    resp_err_d   = misaligned;
                    drop_d       = 1'b0;
                    // Misaligned requests never touch the bus.
                    state_d      = misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                if (cancel) drop_d = 1'b1;
                if (data_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (cancel) drop_d = 1'b1;
                if (data_data_ok) begin
                    // The bus transfer must still drain even when its result is discarded.
                    if (drop_q || cancel) begin
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        resp_rdata_d = data_wr_q ? '0 : data_rdata;
                        resp_err_d   = 1'b0;
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                if (resp_ready || cancel) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            drop_q       <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= 2'd0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            data_wstrb_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            data_wr_q    <= data_wr_d;
            data_size_q  <= data_size_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            data_wstrb_q <= data_wstrb_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign data_req   = (state_q == REQ);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign data_wr    = data_wr_q;
    assign data_size  = data_size_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;
    assign data_wstrb = data_wstrb_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: directed vector table, hand-written corner sequences,
// and randomized transactions checked against a timeline model.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_wr, cancel;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_bus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .cancel       (cancel),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          addr_lat;   // extra data_req cycles before addr_ok
        int          data_lat;   // cycles from address acceptance to data_ok (>=1)
        int          ready_lat;  // RESP cycles with resp_ready low
        int          cancel_at;  // cycle index after acceptance to pulse cancel, -1 none
        logic [31:0] rdata;
        logic        exp_resp;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input int al, input int dl, input int rl, input int ca,
                                input logic [31:0] rdata, input logic er,
                                input logic ee, input logic [31:0] erd);
        vec_t v;
        v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.addr_lat = al; v.data_lat = dl; v.ready_lat = rl; v.cancel_at = ca;
        v.rdata = rdata; v.exp_resp = er; v.exp_err = ee; v.exp_rdata = erd;
        return v;
    endfunction

    function automatic logic ref_mis(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    endfunction

    task automatic idle_inputs();
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; cancel = 1'b0; resp_ready = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    endtask

    // Runs one request, acting as a reactive bus slave, and checks it against a timeline
    // derived from the latencies: REQ lasts addr_lat+1 cycles, WAIT data_lat, RESP ready_lat+1.
    task automatic run_txn(input string tag, input vec_t v);
        int nreq, resp_idx, idle_idx, addr_idx, resp_cnt, n;
        int exp_nreq, exp_resp_idx, exp_idle_idx;
        logic fields_ok, resp_ok;
        exp_nreq     = v.exp_err ? 0 : v.addr_lat + 1;
        exp_resp_idx = v.exp_err ? 0 : (v.exp_resp ? v.addr_lat + v.data_lat + 1 : -1);
        exp_idle_idx = v.exp_resp ? exp_resp_idx + v.ready_lat + 1 : v.addr_lat + v.data_lat + 1;

        @(posedge clk); #1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " idle_before"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wr = v.wr; req_size = v.size; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);

        nreq = 0; resp_idx = -1; idle_idx = -1; addr_idx = -1; resp_cnt = 0;
        fields_ok = 1'b1; resp_ok = 1'b1;
        for (int idx = 0; idx < 100; idx++) begin
            data_addr_ok = 1'b0; data_data_ok = 1'b0; resp_ready = 1'b0; cancel = 1'b0;
            data_rdata = $urandom;
            if (req_ready) begin
                idle_idx = idx;
                break;
            end
            if (data_req) begin
                if (data_wr !== v.wr || data_size !== v.size || data_addr !== v.addr ||
                    data_wdata !== v.wdata || data_wstrb !== (v.wr ? v.wstrb : 4'h0))
                    fields_ok = 1'b0;
                if (nreq == v.addr_lat) begin
                    data_addr_ok = 1'b1;
                    addr_idx = idx;
                end
                nreq++;
            end
            if (addr_idx >= 0 && idx == addr_idx + v.data_lat) begin
                data_data_ok = 1'b1;
                data_rdata = v.rdata;
            end
            if (resp_valid) begin
                if (resp_idx < 0) resp_idx = idx;
                if (resp_rdata !== v.exp_rdata || resp_err !== v.exp_err) resp_ok = 1'b0;
                if (resp_cnt == v.ready_lat) resp_ready = 1'b1;
                resp_cnt++;
            end
            if (idx == v.cancel_at) cancel = 1'b1;
            @(posedge clk); #1;
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0; resp_ready = 1'b0; cancel = 1'b0;

        check({tag, " data_req_cycles"}, 64'(nreq), 64'(exp_nreq));
        if (exp_nreq > 0) check({tag, " bus_fields"}, 64'(fields_ok), 64'd1);
        check({tag, " resp_cycle"}, 64'(resp_idx), 64'(exp_resp_idx));
        if (v.exp_resp) check({tag, " resp_data_err"}, 64'(resp_ok), 64'd1);
        check({tag, " idle_cycle"}, 64'(idle_idx), 64'(exp_idle_idx));
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = mk(0, 2'd2, 32'h8000_0010, 32'h0, 4'h0, 0, 2, 0, -1, 32'hDEAD_BEEF,
                     1, 0, 32'hDEAD_BEEF);
        vecs[1] = mk(1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 4'b1000, 3, 1, 0, -1, 32'h5555_5555,
                     1, 0, 32'h0);
        vecs[2] = mk(0, 2'd1, 32'h8000_0001, 32'h0, 4'h0, 0, 1, 0, -1, 32'h0, 1, 1, 32'h0);
        vecs[3] = mk(0, 2'd2, 32'h8000_0040, 32'h0, 4'h0, 0, 3, 0, 2, 32'h1234_5678, 0, 0, 32'h0);
        vecs[4] = mk(0, 2'd2, 32'h8000_0044, 32'h0, 4'hF, 1, 1, 5, -1, 32'hCAFE_F00D,
                     1, 0, 32'hCAFE_F00D);
        vecs[5] = mk(0, 2'd3, 32'h8000_0000, 32'h0, 4'h0, 0, 1, 2, -1, 32'h0, 1, 1, 32'h0);
        vecs[6] = mk(1, 2'd2, 32'h8000_0008, 32'h1122_3344, 4'hF, 0, 1, 0, -1, 32'hFFFF_FFFF,
                     1, 0, 32'h0);
        vecs[7] = mk(0, 2'd1, 32'h8000_0006, 32'h0, 4'h0, 2, 1, 0, 1, 32'h0BAD_0BAD, 0, 0, 32'h0);
        vecs[8] = mk(0, 2'd0, 32'h8000_0007, 32'h0, 4'h0, 0, 1, 0, 1, 32'h0000_00EE, 0, 0, 32'h0);
        vecs[9] = mk(0, 2'd1, 32'h8000_0002, 32'h0, 4'h0, 0, 1, 1, -1, 32'h0000_BEEF,
                     1, 0, 32'h0000_BEEF);

        idle_inputs();
        resetn = 1'b0;
        #12;
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset outputs", {data_req, data_wr, data_size, resp_valid, resp_err, data_wstrb},
              64'd0);
        check("reset data_addr", 64'(data_addr), 64'd0);
        check("reset resp_rdata", 64'(resp_rdata), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Asynchronous reset while in REQ, then a normal load.
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_addr = 32'h8000_0100;
        req_wdata = 32'h7777_7777; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_mid data_req_before", 64'(data_req), 64'd1);
        resetn = 1'b0;
        #1;
        check("rst_mid data_req", 64'(data_req), 64'd0);
        check("rst_mid req_ready", 64'(req_ready), 64'd1);
        check("rst_mid bus_fields", {data_addr, data_wdata}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_txn("after_reset", vecs[0]);

        // req_valid together with cancel in IDLE must be ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; cancel = 1'b1; req_size = 2'd2; req_addr = 32'h8000_0200;
        @(posedge clk); #1;
        req_valid = 1'b0; cancel = 1'b0;
        check("cancel_accept ignored", {req_ready, data_req, resp_valid}, 64'b100);

        // New request held during RESP is only taken after the handshake.
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0002;
        @(posedge clk); #1;
        req_addr = 32'h8000_0020;
        for (int i = 0; i < 3; i++) begin
            check("queued blocked", {resp_valid, resp_err, req_ready, data_req}, 64'b1100);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("queued idle", {req_ready, resp_valid}, 64'b10);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("queued accepted", {data_req, data_addr}, {31'd0, 1'b1, 32'h8000_0020});
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5A5A_A5A5;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        check("queued resp", {resp_valid, resp_err, resp_rdata}, {30'd0, 2'b10, 32'h5A5A_A5A5});
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("queued done", 64'(req_ready), 64'd1);

        // Randomized transactions against the reference rules.
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            logic mis;
            v.wr = 1'($urandom); v.size = 2'($urandom_range(0, 3));
            v.addr = $urandom; v.wdata = $urandom; v.wstrb = 4'($urandom);
            v.addr_lat = $urandom_range(0, 3); v.data_lat = $urandom_range(1, 3);
            v.ready_lat = $urandom_range(0, 2); v.rdata = $urandom;
            mis = ref_mis(v.size, v.addr);
            v.cancel_at = (!mis && $urandom_range(0, 3) == 0) ?
                          int'($urandom_range(0, v.addr_lat + v.data_lat)) : -1;
            v.exp_err   = mis;
            v.exp_resp  = mis || v.cancel_at < 0;
            v.exp_rdata = (mis || v.wr) ? 32'h0 : v.rdata;
            run_txn($sformatf("rand%0d", i), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Sequential data-memory access controller between the MEM-stage alignment unit and the SRAM-like data bus. It accepts one load/store request at a time from the pipeline and checks its alignment. It runs the two-phase bus handshake (address phase, then data phase) and returns raw read data, or an error, to the pipeline through a valid/ready response port. The MEM-stage alignment unit supplies the byte strobe and consumes the returned raw word.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  bridge can accept; high exactly when state is IDLE
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, already lane-placed
- req_wstrb  in  DATA_W/8  store byte enables from MEM stage
- cancel  in  1  exception/flush: discard the current transaction's result
- resp_valid  out  1  response available
- resp_ready  in  1  pipeline consumes response
- resp_rdata  out  DATA_W  raw read word; 0 for stores and errors
- resp_err  out  1  address-alignment error
- data_req  out  1  bus address-phase request
- data_wr, data_size, data_addr, data_wdata, data_wstrb  out  1/2/ADDR_W/DATA_W/DATA_W/8  registered bus fields
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase complete
- data_rdata  in  DATA_W  bus read data, valid with data_data_ok

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Add a 1-bit `drop` flag.
- IDLE: accept when req_valid && !cancel. Latch all req_* fields into the bus registers.
  - Misaligned request: half with addr[0]=1, word with addr[1:0]!=0, or size 3. Do not access the bus. Go to RESP with err=1 and rdata=0.
  - Otherwise go to REQ.
  - For loads, data_wstrb is forced to 0.
  - req_valid with cancel in the same cycle is ignored.
- REQ: data_req=1 and all bus fields held stable. On data_addr_ok, go to WAIT. data_req must never drop before data_addr_ok. cancel in REQ sets drop.
- WAIT: data_req=0. data_data_ok is sampled only in this state. cancel in WAIT sets drop. On data_data_ok:
  - if drop (or cancel in the same cycle), clear drop and go to IDLE;
  - else capture data_rdata (loads) or 0 (stores) and go to RESP.
- RESP: resp_valid=1; resp_rdata and resp_err held stable. Go to IDLE on resp_ready, or on cancel (no handshake needed).
- resp_valid, resp_rdata, resp_err and data_req are registered or decoded from state only. None depends combinationally on bus inputs.

## Timing
- Reset (resetn low, async): state=IDLE, drop=0, all data_* outputs=0, resp_valid=0, resp_rdata=0, resp_err=0. req_ready=1 while in reset.
- Address-phase latency: data_req is first high the cycle after acceptance.
- Minimum aligned load (addr_ok same cycle as data_req, data_ok next cycle): 4 cycles from acceptance to IDLE with resp_ready=1 throughout. The sequence is accept → REQ → WAIT → RESP.
- Misaligned request: resp_valid the cycle after acceptance; data_req never asserted.
- Back-to-back: a new request can be accepted the cycle after the RESP handshake. There is no pipelining of outstanding transactions; at most 1 is outstanding.
- Reset asserted mid-transaction: return to IDLE immediately. The bus slave is reset by the same resetn.

## Structure
- Shared package dmem_pkg: state enum (IDLE/REQ/WAIT/RESP), size constants SIZE_B=0, SIZE_H=1, SIZE_W=2.
- One natural sub-module: dmem_align_chk, combinational (size, addr[1:0]) → misaligned flag. The same checker is reused by the exception logic.

## Test plan
- Aligned word load, addr=0x80000010, slave addr_ok in 0 cycles, data_ok after 2 cycles, rdata=0xDEADBEEF → one data_req cycle, then resp_valid with resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store, addr=0x80000003, wstrb=4'b1000, wdata=0xAB000000, addr_ok delayed 3 cycles → data_req held 4 cycles with stable fields; resp_rdata=0, resp_err=0.
- Half load at addr=0x80000001 → no data_req ever; resp_valid next cycle with resp_err=1, resp_rdata=0.
- cancel pulsed in WAIT, then data_ok with rdata=0x12345678 → resp_valid never asserted; bridge returns to IDLE and req_ready=1.
- resp_ready held low 5 cycles in RESP, then high → resp_rdata stable for all 6 cycles. A new request presented during RESP is accepted only after the handshake.
- resetn pulsed low while in REQ → data_req=0 and req_ready=1 asynchronously; a following load completes normally.
